stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 4:1 select mux: N_CH input streams of DW bits each, muxed onto one registered output stream with valid/ready handshake.
- Two selection modes: fixed (external select) and round-robin (fair among requesters).
- Grant is locked for a whole packet, delimited by a last flag, so packets are never interleaved.
- Sits between multiple producers and a single shared consumer/bus.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DW, 8, data width per channel in bits.
- SELW, 2, select/channel-index width; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel to grant in fixed mode.
- in_data  input  N_CH*DW  channel k occupies bits [k*DW +: DW].
- in_valid  input  N_CH  per-channel beat valid.
- in_last  input  N_CH  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  N_CH  per-channel accept.
- out_data  output  DW  registered output data.
- out_valid  output  1  output beat valid.
- out_last  output  1  output end-of-packet.
- out_ch  output  SELW  source channel of the current out beat.
- out_ready  input  1  consumer accept.
- busy  output  1  high while in LOCKED.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, grant=0, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0, busy=0. Reset mid-packet abandons the packet; any pending out beat is dropped.
- States: IDLE and LOCKED.
- IDLE:
  - in_ready=0.
  - mode and sel are sampled only in IDLE.
  - mode=0: if in_valid[sel]=1, then grant<=sel and go LOCKED next cycle. Otherwise stay in IDLE.
  - mode=1: search in_valid from rr_ptr upward, wrapping modulo N_CH. The first set channel becomes grant; go LOCKED. If none is set, stay in IDLE.
  - sel >= N_CH in fixed mode: no grant; stay in IDLE.
- LOCKED:
  - busy=1.
  - in_ready[grant] = !out_valid || out_ready. All other in_ready bits are 0.
  - Accept = in_valid[grant] && in_ready[grant].
  - On accept, at the next edge: out_data<=in_data[grant], out_last<=in_last[grant], out_ch<=grant, out_valid<=1.
  - When out_valid && out_ready and there is no new accept, out_valid<=0.
  - Simultaneous drain and accept: out_valid stays 1 and the register is reloaded. This gives full throughput of 1 beat/cycle.
  - Accepted beat with in_last=1: go IDLE next cycle and set rr_ptr <= (grant+1) mod N_CH, in both modes.
  - Changes on mode/sel while LOCKED are ignored.
- Output holding: while out_valid=1 and out_ready=0, out_data, out_last and out_ch hold stable.
- Latency:
  - Valid seen in IDLE → LOCKED the next cycle → first accept that cycle → out_valid the cycle after. Minimum 2 cycles from in_valid to out_valid.
  - Exactly one idle (re-arbitration) cycle between packets.
- The output register may still hold the last beat after the return to IDLE; it drains normally.
- Single-beat packet (in_last=1 on the first beat) is legal: one LOCKED cycle, then IDLE.
- Non-granted channels see in_ready=0 and must hold their data.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 → all outputs 0, in_ready=0, busy=0. First grant in mode=1 is ch0.
- Fixed mode: mode=0, sel=2, ch2 sends a 3-beat packet 0x11,0x22,0x33 (last on 0x33), out_ready=1 → out sees 0x11,0x22,0x33 on consecutive cycles, out_ch=2, out_last only on 0x33; ch0 and ch1 in_ready stay 0.
- Round-robin fairness: mode=1, all four channels continuously valid with 1-beat packets (data=0xA0+ch) → out order ch0,ch1,ch2,ch3,ch0..., one bubble cycle between beats.
- Backpressure: LOCKED on ch1, out_ready held 0 for 3 cycles mid-packet → out_data stable, in_ready[1]=0 after the register fills. Release → no beat lost or duplicated.
- Lock integrity: mode=1, ch3 mid 4-beat packet; ch0 asserts valid and sel/mode toggle → ch3 packet completes uninterrupted; next grant is ch0 (rr_ptr wraps 3→0).
- Reset mid-packet: rst=1 during beat 2 of a ch1 packet → next cycle out_valid=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 valid/ready stream mux with a registered output.
// Arbitration is either fixed (external select) or round-robin, and a grant
// is held for a whole packet so beats from different sources never interleave.
module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int SELW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH-1:0]      in_last,
  output logic [N_CH-1:0]      in_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_grant, r_rr_ptr;
  logic [SELW-1:0] w_pick;
  logic            w_found;
  logic            w_slot_free, w_accept, w_grant_last;
  logic [DW-1:0]   w_grant_data;
  logic [DW-1:0]   w_ch_data [N_CH];

  logic [DW-1:0]   r_out_data;
  logic            r_out_valid, r_out_last;
  logic [SELW-1:0] r_out_ch;

  // Unpack the flat input bus into one word per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_data[k] = in_data[k*DW +: DW];
  end

  assign w_grant_data = w_ch_data[r_grant];
  assign w_grant_last = in_last[r_grant];
  // Output register can take a beat when empty or draining this cycle.
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_accept     = (r_state == S_LOCKED) && in_valid[r_grant] && w_slot_free;
  assign busy         = (r_state == S_LOCKED);

  // Candidate grant: external select, or first requester at/after rr_ptr.
  always_comb begin : arb
    logic [SELW-1:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    if (!mode) begin
      if ((int'(sel) < N_CH) && in_valid[sel]) begin
        w_found = 1'b1;
        w_pick  = sel;
      end
    end else begin
      // Walk from the farthest offset down so the nearest requester wins.
      for (int i = N_CH-1; i >= 0; i--) begin
        idx = SELW'((int'(r_rr_ptr) + i) % N_CH);
        if (in_valid[idx]) begin
          w_found = 1'b1;
          w_pick  = idx;
        end
      end
    end
  end

  // Only the locked channel ever sees ready.
  always_comb begin : ready_gen
    in_ready = '0;
    if (r_state == S_LOCKED) in_ready[r_grant] = w_slot_free;
  end

  // Next-state: lock on a found requester, release after the last beat.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_accept && w_grant_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant capture in IDLE; round-robin pointer advances past a finished packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (w_accept && w_grant_last)
        r_rr_ptr <= (int'(r_grant) == N_CH-1) ? '0 : r_grant + 1'b1;
    end
  end

  // Output register: load on accept, clear valid on drain without reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_last  <= w_grant_last;
      r_out_ch    <= r_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_CH=4, DW=8).
module tb_stream_mux_rr;

  logic        clk, rst, mode, out_ready;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy;
  logic [1:0]  out_ch;

  int errs = 0;
  int chks = 0;
  int cyc  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] ch;
    int         c;
  } beat_t;
  beat_t q[$];

  stream_mux_rr #(.N_CH(4), .DW(8), .SELW(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat the consumer takes.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && out_valid && out_ready)
      q.push_back('{d: out_data, l: out_last, ch: out_ch, c: cyc});
  end

  task automatic set_ch(input logic [1:0] ch, input logic [7:0] d,
                        input logic v, input logic l);
    in_data[{ch, 3'b000} +: 8] = d;
    in_valid[ch] = v;
    in_last[ch]  = l;
  endtask

  // Producer: presents beats d0, d0+dstep, ... and advances only after accept.
  task automatic send_pkt(input logic [1:0] ch, input int nb,
                          input logic [7:0] d0, input logic [7:0] dstep);
    int i = 0;
    int g = 0;
    logic [7:0] d = d0;
    set_ch(ch, d, 1'b1, nb == 1);
    while (i < nb && g < 200) begin
      @(negedge clk); #1;
      if (in_ready[ch]) begin
        i++;
        @(posedge clk); #1;
        d = d + dstep;
        if (i < nb) set_ch(ch, d, 1'b1, i == nb-1);
        else        in_valid[ch] = 1'b0;
      end
      g++;
    end
    chks++;
    if (i != nb) begin
      errs++;
      $display("FAIL send_pkt ch%0d timeout: sent %0d of %0d", ch, i, nb);
      in_valid[ch] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(2'(k), 8'hA0 + 8'(k), 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    chks++; if (out_data !== 8'h00) begin errs++; $display("FAIL rst_out_data got %h exp 00", out_data); end
    chks++; if (out_last !== 1'b0) begin errs++; $display("FAIL rst_out_last got %b exp 0", out_last); end
    chks++; if (out_ch !== 2'd0) begin errs++; $display("FAIL rst_out_ch got %0d exp 0", out_ch); end
    chks++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL rst_in_ready got %b exp 0000", in_ready); end
    chks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    chks++; if (busy !== 1'b1) begin errs++; $display("FAIL first_grant_busy got %b exp 1", busy); end
    chks++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL first_grant_ready got %b exp 0001", in_ready); end
    @(negedge clk);
    chks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_ch !== 2'd0 || out_last !== 1'b1) begin
      errs++; $display("FAIL first_beat got v=%b d=%h ch=%0d l=%b exp v=1 d=a0 ch=0 l=1",
                       out_valid, out_data, out_ch, out_last);
    end
    chks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_beat_release busy got %b exp 0", busy); end
    in_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2;
    set_ch(2'd0, 8'h55, 1'b1, 1'b0);
    set_ch(2'd1, 8'h66, 1'b1, 1'b0);
    q.delete();
    fork
      send_pkt(2'd2, 3, 8'h11, 8'h11);
      begin
        repeat (8) begin
          @(negedge clk);
          chks++;
          if (in_ready[1:0] !== 2'b00) begin
            errs++; $display("FAIL fixed_other_ready got %b exp 00", in_ready[1:0]);
          end
        end
      end
    join
    in_valid = '0;
    repeat (2) @(negedge clk);
    chks++;
    if (q.size() != 3) begin
      errs++; $display("FAIL fixed_count got %0d exp 3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        chks++;
        if (q[i].d !== 8'h11 * 8'(i+1) || q[i].ch !== 2'd2 || q[i].l !== (i == 2) ||
            q[i].c !== q[0].c + i) begin
          errs++; $display("FAIL fixed_beat%0d got d=%h ch=%0d l=%b dc=%0d exp d=%h ch=2 l=%b dc=%0d",
                           i, q[i].d, q[i].ch, q[i].l, q[i].c - q[0].c, 8'h11 * 8'(i+1), i == 2, i);
        end
      end
    end
  endtask

  task automatic test_rr();
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(2'(k), 8'hA0 + 8'(k), 1'b1, 1'b1);
    q.delete();
    repeat (20) @(negedge clk);
    in_valid = '0;
    repeat (3) @(negedge clk);
    chks++;
    if (q.size() < 8) begin
      errs++; $display("FAIL rr_count got %0d exp >=8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        chks++;
        if (q[i].ch !== 2'(i % 4) || q[i].d !== 8'hA0 + 8'(i % 4) || q[i].l !== 1'b1) begin
          errs++; $display("FAIL rr_beat%0d got ch=%0d d=%h l=%b exp ch=%0d d=%h l=1",
                           i, q[i].ch, q[i].d, q[i].l, i % 4, 8'hA0 + 8'(i % 4));
        end
        if (i > 0) begin
          chks++;
          if (q[i].c - q[i-1].c !== 2) begin
            errs++; $display("FAIL rr_gap%0d got %0d exp 2", i, q[i].c - q[i-1].c);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd1;
    q.delete();
    fork
      send_pkt(2'd1, 5, 8'h40, 8'h01);
      begin
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin @(negedge clk); g++; end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chks++;
          if (out_valid !== 1'b1 || out_data !== 8'h40 || out_ch !== 2'd1 || in_ready[1] !== 1'b0) begin
            errs++; $display("FAIL bp_hold got v=%b d=%h ch=%0d rdy=%b exp v=1 d=40 ch=1 rdy=0",
                             out_valid, out_data, out_ch, in_ready[1]);
          end
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chks++;
    if (q.size() != 5) begin
      errs++; $display("FAIL bp_count got %0d exp 5", q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        chks++;
        if (q[i].d !== 8'h40 + 8'(i) || q[i].ch !== 2'd1 || q[i].l !== (i == 4)) begin
          errs++; $display("FAIL bp_beat%0d got d=%h ch=%0d l=%b exp d=%h ch=1 l=%b",
                           i, q[i].d, q[i].ch, q[i].l, 8'h40 + 8'(i), i == 4);
        end
      end
    end
  endtask

  task automatic test_lock();
    int g = 0;
    do_reset();
    mode = 1'b1; sel = 2'd3;
    q.delete();
    fork
      send_pkt(2'd3, 4, 8'h30, 8'h01);
      begin
        int w = 0;
        @(negedge clk);
        while (!busy && w < 50) begin @(negedge clk); w++; end
        set_ch(2'd0, 8'hC0, 1'b1, 1'b1);
        mode = 1'b0; sel = 2'd0;
        for (int s = 0; s < 3; s++) begin
          if (s == 1) sel = 2'd1;
          if (s == 2) mode = 1'b1;
          chks++;
          if (in_ready[0] !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL lock_hold%0d got rdy0=%b busy=%b exp rdy0=0 busy=1", s, in_ready[0], busy);
          end
          @(negedge clk);
        end
      end
    join
    // Retire ch0's single beat once it is granted.
    @(negedge clk); #1;
    while (!in_ready[0] && g < 50) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chks++;
    if (q.size() != 5) begin
      errs++; $display("FAIL lock_count got %0d exp 5", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        chks++;
        if (q[i].d !== 8'h30 + 8'(i) || q[i].ch !== 2'd3 || q[i].l !== (i == 3)) begin
          errs++; $display("FAIL lock_beat%0d got d=%h ch=%0d l=%b exp d=%h ch=3 l=%b",
                           i, q[i].d, q[i].ch, q[i].l, 8'h30 + 8'(i), i == 3);
        end
      end
      chks++;
      if (q[4].d !== 8'hC0 || q[4].ch !== 2'd0 || q[4].l !== 1'b1) begin
        errs++; $display("FAIL lock_next_grant got d=%h ch=%0d l=%b exp d=c0 ch=0 l=1",
                         q[4].d, q[4].ch, q[4].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Single-beat ch0 packet moves rr_ptr to 1 so the reset is observable.
    mode = 1'b0; sel = 2'd0;
    set_ch(2'd0, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    sel = 2'd1;
    set_ch(2'd1, 8'h50, 1'b1, 1'b0);
    @(negedge clk);
    chks++; if (busy !== 1'b1 || in_ready !== 4'b0010) begin
      errs++; $display("FAIL mid_lock got busy=%b rdy=%b exp busy=1 rdy=0010", busy, in_ready);
    end
    @(negedge clk);
    chks++; if (out_valid !== 1'b1 || out_data !== 8'h50) begin
      errs++; $display("FAIL mid_beat1 got v=%b d=%h exp v=1 d=50", out_valid, out_data);
    end
    set_ch(2'd1, 8'h51, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errs++; $display("FAIL mid_rst_out got v=%b d=%h exp v=0 d=00", out_valid, out_data);
    end
    chks++; if (busy !== 1'b0 || in_ready !== 4'b0000) begin
      errs++; $display("FAIL mid_rst_idle got busy=%b rdy=%b exp busy=0 rdy=0000", busy, in_ready);
    end
    rst = 1'b0; mode = 1'b1;
    in_valid = '0;
    set_ch(2'd0, 8'hE0, 1'b1, 1'b1);
    set_ch(2'd2, 8'hE2, 1'b1, 1'b1);
    @(negedge clk);
    chks++; if (busy !== 1'b1 || in_ready !== 4'b0001) begin
      errs++; $display("FAIL mid_rr_ptr got busy=%b rdy=%b exp busy=1 rdy=0001", busy, in_ready);
    end
    in_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_data = '0; in_valid = '0; in_last = '0;
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_lock();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
